// File: rtl/seg7_pkg.sv
// Seven-segment glyph helpers shared by the board display wrappers.
// Segments are active-low, bit0 = segment a.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises and debounces one active-low push button; emits a single-cycle
// pulse when a press is accepted, nothing on release.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // press is combinational off flops so the page steps on the same edge the level flips
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press   = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press   = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/hex_page_display.sv
// Paged 7-segment viewer: snapshots a wide word and shows NUM_DIGITS nibbles
// per page, stepped with two debounced buttons.
module hex_page_display
    import seg7_pkg::*;
#(
    parameter int DATA_W       = 128,
    parameter int NUM_DIGITS   = 6,
    parameter int DEBOUNCE_CYC = 500000,
    localparam int NIBBLES     = DATA_W / 4,
    localparam int NUM_PAGES   = (NIBBLES + NUM_DIGITS - 1) / NUM_DIGITS,
    localparam int PAGE_W      = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    load,
    input  logic                    hold,
    input  logic                    btn_next_n,
    input  logic                    btn_prev_n,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic [PAGE_W-1:0]       page,
    output logic                    fresh
);

    localparam int SLOTS = NUM_PAGES * NUM_DIGITS;
    // one spare bit so NIBBLES itself is representable for the blanking compare
    localparam int IDX_W = $clog2(SLOTS + 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_PAGES - 1);

    logic [DATA_W-1:0]       snap_q, snap_d;
    logic [PAGE_W-1:0]       page_q, page_d;
    logic                    fresh_q, fresh_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d, hex_rst;
    logic [4*SLOTS-1:0]      padded;
    logic                    press_next, press_prev;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_next (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .btn_n    (btn_next_n),
        .press    (press_next)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_prev (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .btn_n    (btn_prev_n),
        .press    (press_prev)
    );

    assign padded = (4 * SLOTS)'(snap_q);

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        logic [IDX_W-1:0] idx;
        assign idx = IDX_W'(page_q) * IDX_W'(NUM_DIGITS) + IDX_W'(d);
        assign hex_d[7*d +: 7] = (idx >= IDX_W'(NIBBLES)) ? SEG_BLANK
                                                          : hex_to_seg7(padded[{idx, 2'b00} +: 4]);
        assign hex_rst[7*d +: 7] = (d >= NIBBLES) ? SEG_BLANK : SEG_ZERO;
    end

    // simultaneous next/prev cancel; a capture overrides the fresh-clear of a step
    always_comb begin
        snap_d  = snap_q;
        page_d  = page_q;
        fresh_d = fresh_q;
        if (press_next && !press_prev) begin
            page_d  = (page_q == PAGE_LAST) ? '0 : page_q + 1'b1;
            fresh_d = 1'b0;
        end else if (press_prev && !press_next) begin
            page_d  = (page_q == '0) ? PAGE_LAST : page_q - 1'b1;
            fresh_d = 1'b0;
        end
        if (load && !hold) begin
            snap_d  = data_in;
            fresh_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            snap_q  <= '0;
            page_q  <= '0;
            fresh_q <= 1'b0;
            hex_q   <= hex_rst;
        end else begin
            snap_q  <= snap_d;
            page_q  <= page_d;
            fresh_q <= fresh_d;
            hex_q   <= hex_d;
        end
    end

    assign hex_out = hex_q;
    assign page    = page_q;
    assign fresh   = fresh_q;

endmodule

// File: tb/tb_hex_page_display.sv
// Scoreboard bench for hex_page_display: a cycle-level reference model pushes
// expected outputs per edge; a monitor pops and compares on the falling edge.
module tb_hex_page_display;

    localparam int DW  = 128;
    localparam int ND  = 6;
    localparam int DC  = 4;
    localparam int NIB = 32;
    localparam int NP  = 6;

    localparam logic [6:0] GLY [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    localparam logic [6:0] BLK = 7'b1111111;

    logic            CLOCK_50 = 1'b0;
    logic            reset_n = 1'b0;
    logic [DW-1:0]   data_in = '0;
    logic            load = 1'b0, hold = 1'b0;
    logic            btn_next_n = 1'b1, btn_prev_n = 1'b1;
    logic [7*ND-1:0] hex_out;
    logic [2:0]      page;
    logic            fresh;

    always #5 CLOCK_50 = ~CLOCK_50;

    hex_page_display #(.DATA_W(DW), .NUM_DIGITS(ND), .DEBOUNCE_CYC(DC)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .load       (load),
        .hold       (hold),
        .btn_next_n (btn_next_n),
        .btn_prev_n (btn_prev_n),
        .hex_out    (hex_out),
        .page       (page),
        .fresh      (fresh)
    );

    typedef struct {
        logic [7*ND-1:0] hex;
        logic [2:0]      page;
        logic            fresh;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0, n_bad = 0;

    // reference state
    logic [DW-1:0] m_snap = '0;
    int  m_page = 0;
    bit  m_fresh = 0;
    int  run_n = 0, run_p = 0, hi_n = 0, hi_p = 0, cd_n = 0, cd_p = 0;
    bit  arm_n = 1, arm_p = 1;

    function automatic logic [7*ND-1:0] render(input logic [DW-1:0] s, input int p);
        logic [7*ND-1:0] r;
        for (int d = 0; d < ND; d++) begin
            int n;
            n = p * ND + d;
            r[7*d +: 7] = (n >= NIB) ? BLK : GLY[s[4*n +: 4]];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // a press is a run of DC low samples; the step lands two edges later (synchroniser)
    task automatic btn_model(input bit raw, inout int run, inout int hi, inout int cd, inout bit arm);
        if (!raw) begin
            hi = 0;
            run++;
            if (run == DC && arm) begin
                cd  = 2;
                arm = 0;
            end
        end else begin
            run = 0;
            hi++;
            if (hi >= DC) arm = 1;
        end
    endtask

    task automatic tick(input bit nn, input bit pn, input bit ld, input bit hd,
                        input logic [DW-1:0] din, input bit rst_n);
        exp_t e;
        bit fn, fp;
        btn_next_n = nn;
        btn_prev_n = pn;
        load       = ld;
        hold       = hd;
        data_in    = din;
        reset_n    = rst_n;
        @(posedge CLOCK_50);
        #1;
        if (!rst_n) begin
            e.hex = render('0, 0);
            m_snap = '0; m_page = 0; m_fresh = 0;
            run_n = 0; run_p = 0; hi_n = 0; hi_p = 0; cd_n = 0; cd_p = 0;
            arm_n = 1; arm_p = 1;
        end else begin
            e.hex = render(m_snap, m_page);
            fn = (cd_n == 1);
            fp = (cd_p == 1);
            if (cd_n > 0) cd_n--;
            if (cd_p > 0) cd_p--;
            btn_model(nn, run_n, hi_n, cd_n, arm_n);
            btn_model(pn, run_p, hi_p, cd_p, arm_p);
            if (fn && !fp) begin
                m_page = (m_page + 1) % NP;
                m_fresh = 0;
            end else if (fp && !fn) begin
                m_page = (m_page + NP - 1) % NP;
                m_fresh = 0;
            end
            if (ld && !hd) begin
                m_snap = din;
                m_fresh = 1;
            end
        end
        e.page  = 3'(m_page);
        e.fresh = m_fresh;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1, 1, 0, 0, '0, 1);
    endtask

    task automatic press(input bit nxt, input bit prv, input int len);
        for (int i = 0; i < len; i++) tick(!nxt, !prv, 0, 0, '0, 1);
        idle(10);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLOCK_50);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_hex",   64'(hex_out), 64'(e.hex));
                chk("sb_page",  64'(page),    64'(e.page));
                chk("sb_fresh", 64'(fresh),   64'(e.fresh));
            end
        end
    end

    initial begin : stim
        logic [DW-1:0] d1;
        logic [DW-1:0] rnd;
        d1 = 128'h00112233445566778899aabbccddeabc;
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, '0, 0);
        @(negedge CLOCK_50);
        chk("rst_hex", 64'(hex_out), 64'({6{7'b1000000}}));

        tick(1, 1, 1, 0, d1, 1);
        idle(2);
        @(negedge CLOCK_50);
        chk("t1_hex", 64'(hex_out), 64'({7'b0100001, 7'b0100001, 7'b0000110,
                                         7'b0001000, 7'b0000011, 7'b1000110}));
        chk("t1_fresh", 64'(fresh), 64'd1);

        press(1, 0, 20);
        @(negedge CLOCK_50);
        chk("t2_page", 64'(page), 64'd1);
        chk("t2_hex", 64'(hex_out), 64'({7'b0001000, 7'b0001000, 7'b0000011,
                                         7'b0000011, 7'b1000110, 7'b1000110}));
        chk("t2_fresh", 64'(fresh), 64'd0);

        press(1, 0, 3);
        @(negedge CLOCK_50);
        chk("t3_glitch_page", 64'(page), 64'd1);
        press(0, 1, 6);
        press(0, 1, 6);
        @(negedge CLOCK_50);
        chk("t3_wrap_page", 64'(page), 64'd5);
        chk("t3_blank_hex", 64'(hex_out), 64'({BLK, BLK, BLK, BLK, 7'b1000000, 7'b1000000}));

        press(1, 1, 6);
        @(negedge CLOCK_50);
        chk("t4_both_page", 64'(page), 64'd5);
        tick(1, 1, 1, 1, {4{32'hdeadbeef}}, 1);
        idle(3);
        @(negedge CLOCK_50);
        chk("t4_hold_fresh", 64'(fresh), 64'd0);
        chk("t4_hold_hex", 64'(hex_out), 64'({BLK, BLK, BLK, BLK, 7'b1000000, 7'b1000000}));

        for (int i = 0; i < 5; i++) press(1, 0, 6);
        @(negedge CLOCK_50);
        chk("t5_page", 64'(page), 64'd4);
        tick(0, 1, 0, 0, '0, 1);
        tick(0, 1, 0, 0, '0, 1);
        tick(0, 1, 0, 0, '0, 0);
        tick(0, 1, 0, 0, '0, 0);
        idle(15);
        @(negedge CLOCK_50);
        chk("t5_rst_page", 64'(page), 64'd0);
        chk("t5_rst_hex", 64'(hex_out), 64'({6{7'b1000000}}));

        for (int ep = 0; ep < 60; ep++) begin
            int kind, len, gap;
            bit nx, pv;
            kind = $urandom_range(0, 3);
            len  = $urandom_range(1, 8);
            gap  = $urandom_range(8, 12);
            nx = (kind == 0 || kind == 2);
            pv = (kind == 1 || kind == 2);
            for (int i = 0; i < len; i++) begin
                rnd = {$urandom, $urandom, $urandom, $urandom};
                tick(!nx, !pv, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), rnd, 1);
            end
            for (int i = 0; i < gap; i++) begin
                rnd = {$urandom, $urandom, $urandom, $urandom};
                tick(1, 1, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), rnd,
                     !(i == 2 && $urandom_range(0, 19) == 0));
            end
        end

        idle(2);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge CLOCK_50);
        #2;
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
